// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32IM pipeline: decides hold, flush and bubble
// for every pipeline register each cycle and keeps saturating stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int MD_TIMEOUT = 64,
    parameter int TO_W       = 7,
    parameter int CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             MEM_BUSYWAIT,
    input  logic             BJ_TAKEN_EX,
    input  logic             MEM_READ_EN_IDEX,
    input  logic [4:0]       REG_WRITE_ADDR_IDEX,
    input  logic [4:0]       ADDR_1_ID,
    input  logic [4:0]       ADDR_2_ID,
    input  logic             USES_RS1_ID,
    input  logic             USES_RS2_ID,
    input  logic             MD_REQ_EX,
    input  logic             MD_DONE,
    output logic             PC_HOLD,
    output logic             IFID_HOLD,
    output logic             IFID_FLUSH,
    output logic             IDEX_RESET,
    output logic             PIPE_HOLD,
    output logic             MD_START,
    output logic             MD_ERR,
    output logic [1:0]       STATE,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_MD_BUSY = 2'd1;
    localparam logic [1:0] ST_MD_HELD = 2'd2;

    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(MD_TIMEOUT - 1);
    localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1'b1);
    localparam logic [TO_W-1:0]  TO_ZERO = {TO_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]      state_r;
    logic [1:0]      next_state_s;
    logic [TO_W-1:0] to_cnt_r;
    logic [TO_W-1:0] to_cnt_next_s;
    logic            md_err_r;
    logic            err_set_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    logic load_use_s;
    logic pc_hold_s;
    logic ifid_hold_s;
    logic ifid_flush_s;
    logic idex_reset_s;
    logic pipe_hold_s;
    logic md_start_s;

    assign load_use_s = MEM_READ_EN_IDEX && (REG_WRITE_ADDR_IDEX != 5'd0) &&
                        ((USES_RS1_ID && (ADDR_1_ID == REG_WRITE_ADDR_IDEX)) ||
                         (USES_RS2_ID && (ADDR_2_ID == REG_WRITE_ADDR_IDEX)));

    // Mealy hazard decode and next-state selection; everything is quiet while in reset
    always_comb begin
        pc_hold_s     = 1'b0;
        ifid_hold_s   = 1'b0;
        ifid_flush_s  = 1'b0;
        idex_reset_s  = 1'b0;
        pipe_hold_s   = 1'b0;
        md_start_s    = 1'b0;
        err_set_s     = 1'b0;
        next_state_s  = state_r;
        to_cnt_next_s = to_cnt_r;
        if (!RESET_N) begin
            next_state_s  = ST_RUN;
            to_cnt_next_s = TO_ZERO;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (MEM_BUSYWAIT) begin
                        pc_hold_s   = 1'b1;
                        ifid_hold_s = 1'b1;
                        pipe_hold_s = 1'b1;
                    end else if (BJ_TAKEN_EX) begin
                        ifid_flush_s = 1'b1;
                        idex_reset_s = 1'b1;
                    end else if (MD_REQ_EX) begin
                        md_start_s    = 1'b1;
                        pc_hold_s     = 1'b1;
                        ifid_hold_s   = 1'b1;
                        pipe_hold_s   = 1'b1;
                        next_state_s  = ST_MD_BUSY;
                        to_cnt_next_s = TO_ZERO;
                    end else if (load_use_s) begin
                        pc_hold_s    = 1'b1;
                        ifid_hold_s  = 1'b1;
                        idex_reset_s = 1'b1;
                    end else begin
                        next_state_s = ST_RUN;
                    end
                end
                ST_MD_BUSY: begin
                    to_cnt_next_s = to_cnt_r + TO_ONE;
                    if (MD_DONE) begin
                        // Memory still busy: park the finished result until EX/MEM can take it
                        pc_hold_s    = MEM_BUSYWAIT;
                        ifid_hold_s  = MEM_BUSYWAIT;
                        pipe_hold_s  = MEM_BUSYWAIT;
                        next_state_s = MEM_BUSYWAIT ? ST_MD_HELD : ST_RUN;
                    end else if (to_cnt_r == TO_LAST) begin
                        err_set_s    = 1'b1;
                        pc_hold_s    = MEM_BUSYWAIT;
                        ifid_hold_s  = MEM_BUSYWAIT;
                        pipe_hold_s  = MEM_BUSYWAIT;
                        next_state_s = ST_RUN;
                    end else begin
                        pc_hold_s   = 1'b1;
                        ifid_hold_s = 1'b1;
                        pipe_hold_s = 1'b1;
                    end
                end
                ST_MD_HELD: begin
                    if (MEM_BUSYWAIT) begin
                        pc_hold_s   = 1'b1;
                        ifid_hold_s = 1'b1;
                        pipe_hold_s = 1'b1;
                    end else begin
                        next_state_s = ST_RUN;
                    end
                end
                default: begin
                    next_state_s = ST_RUN;
                end
            endcase
        end
    end

    // Sequencer state, MUL/DIV timeout counter and sticky error flag
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r  <= ST_RUN;
            to_cnt_r <= TO_ZERO;
            md_err_r <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            to_cnt_r <= to_cnt_next_s;
            md_err_r <= md_err_r | err_set_s;
        end
    end

    // Saturating performance counters for stall and flush cycles
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (pc_hold_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (ifid_flush_s && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign PC_HOLD    = pc_hold_s;
    assign IFID_HOLD  = ifid_hold_s;
    assign IFID_FLUSH = ifid_flush_s;
    assign IDEX_RESET = idex_reset_s;
    assign PIPE_HOLD  = pipe_hold_s;
    assign MD_START   = md_start_s;
    assign MD_ERR     = md_err_r;
    assign STATE      = state_r;
    assign STALL_CNT  = stall_cnt_r;
    assign FLUSH_CNT  = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: RUN-state vector table, hand-written multi-cycle
// sequences and a randomized run against a behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int MD_TIMEOUT = 8;
    localparam int TO_W       = 7;
    localparam int CNT_W      = 4;
    localparam int CNT_SAT    = 15;

    logic             CLK = 1'b0;
    logic             RESET_N;
    logic             MEM_BUSYWAIT, BJ_TAKEN_EX, MEM_READ_EN_IDEX;
    logic [4:0]       REG_WRITE_ADDR_IDEX, ADDR_1_ID, ADDR_2_ID;
    logic             USES_RS1_ID, USES_RS2_ID, MD_REQ_EX, MD_DONE;
    logic             PC_HOLD, IFID_HOLD, IFID_FLUSH, IDEX_RESET, PIPE_HOLD, MD_START, MD_ERR;
    logic [1:0]       STATE;
    logic [CNT_W-1:0] STALL_CNT, FLUSH_CNT;
    logic [5:0]       ctrl;

    int n_tests = 0;
    int n_fail  = 0;

    pipeline_hazard_ctrl #(.MD_TIMEOUT(MD_TIMEOUT), .TO_W(TO_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .MEM_BUSYWAIT(MEM_BUSYWAIT), .BJ_TAKEN_EX(BJ_TAKEN_EX),
        .MEM_READ_EN_IDEX(MEM_READ_EN_IDEX), .REG_WRITE_ADDR_IDEX(REG_WRITE_ADDR_IDEX),
        .ADDR_1_ID(ADDR_1_ID), .ADDR_2_ID(ADDR_2_ID), .USES_RS1_ID(USES_RS1_ID),
        .USES_RS2_ID(USES_RS2_ID), .MD_REQ_EX(MD_REQ_EX), .MD_DONE(MD_DONE),
        .PC_HOLD(PC_HOLD), .IFID_HOLD(IFID_HOLD), .IFID_FLUSH(IFID_FLUSH),
        .IDEX_RESET(IDEX_RESET), .PIPE_HOLD(PIPE_HOLD), .MD_START(MD_START), .MD_ERR(MD_ERR),
        .STATE(STATE), .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
    );

    always #5 CLK = ~CLK;

    // {PC_HOLD, IFID_HOLD, IFID_FLUSH, IDEX_RESET, PIPE_HOLD, MD_START}
    assign ctrl = {PC_HOLD, IFID_HOLD, IFID_FLUSH, IDEX_RESET, PIPE_HOLD, MD_START};

    localparam logic [5:0] C_NONE  = 6'b000000;
    localparam logic [5:0] C_HOLD  = 6'b110010;
    localparam logic [5:0] C_LAUNCH = 6'b110011;
    localparam logic [5:0] C_REDIR = 6'b001100;
    localparam logic [5:0] C_LU    = 6'b110100;

    typedef struct {
        logic       busy, bj, mre;
        logic [4:0] rd, a1, a2;
        logic       u1, u2, req, done;
        logic [5:0] exp_ctrl;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic busy, input logic bj, input logic mre, input logic [4:0] rd,
                         input logic [4:0] a1, input logic [4:0] a2, input logic u1,
                         input logic u2, input logic req, input logic done);
        MEM_BUSYWAIT = busy; BJ_TAKEN_EX = bj; MEM_READ_EN_IDEX = mre;
        REG_WRITE_ADDR_IDEX = rd; ADDR_1_ID = a1; ADDR_2_ID = a2;
        USES_RS1_ID = u1; USES_RS2_ID = u2; MD_REQ_EX = req; MD_DONE = done;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET_N = 1'b0;
        idle();
        @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    // Behavioural model: an MD operation is either waiting on the unit or waiting on memory
    bit md_op, md_mem_wait, m_err;
    int md_cycles, m_stalls, m_flushes;

    function automatic logic m_load_use();
        return MEM_READ_EN_IDEX && REG_WRITE_ADDR_IDEX != 0 &&
               ((USES_RS1_ID && ADDR_1_ID == REG_WRITE_ADDR_IDEX) ||
                (USES_RS2_ID && ADDR_2_ID == REG_WRITE_ADDR_IDEX));
    endfunction

    function automatic logic [5:0] m_ctrl();
        logic hold;
        if (!md_op) begin
            if (MEM_BUSYWAIT)     return C_HOLD;
            if (BJ_TAKEN_EX)      return C_REDIR;
            if (MD_REQ_EX)        return C_LAUNCH;
            if (m_load_use())     return C_LU;
            return C_NONE;
        end
        hold = MEM_BUSYWAIT ||
               (!md_mem_wait && !MD_DONE && md_cycles != MD_TIMEOUT - 1);
        return hold ? C_HOLD : C_NONE;
    endfunction

    function automatic logic [1:0] m_state();
        return !md_op ? 2'd0 : (md_mem_wait ? 2'd2 : 2'd1);
    endfunction

    task automatic m_clock(input logic [5:0] c);
        if (c[5]) m_stalls  = (m_stalls  < CNT_SAT) ? m_stalls + 1  : CNT_SAT;
        if (c[3]) m_flushes = (m_flushes < CNT_SAT) ? m_flushes + 1 : CNT_SAT;
        if (!md_op) begin
            if (c[0]) begin md_op = 1; md_mem_wait = 0; md_cycles = 0; end
        end else if (md_mem_wait) begin
            if (!MEM_BUSYWAIT) md_op = 0;
        end else if (MD_DONE) begin
            if (MEM_BUSYWAIT) md_mem_wait = 1; else md_op = 0;
        end else if (md_cycles == MD_TIMEOUT - 1) begin
            m_err = 1; md_op = 0;
        end else begin
            md_cycles++;
        end
    endtask

    initial begin
        RESET_N = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        check("rst_ctrl", ctrl, C_NONE);
        repeat (2) @(posedge CLK);
        #1;
        check("rst_state", STATE, 2'd0);
        check("rst_cnts", {STALL_CNT, FLUSH_CNT, 3'b000, MD_ERR}, 0);

        // RUN-state vector table
        vecs[0]  = '{1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,1'b0, C_NONE};
        vecs[1]  = '{1'b1,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,1'b0, C_HOLD};
        vecs[2]  = '{1'b0,1'b1,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,1'b0, C_REDIR};
        vecs[3]  = '{1'b0,1'b1,1'b1,5'd5,5'd1,5'd5,1'b1,1'b1,1'b0,1'b0, C_REDIR};
        vecs[4]  = '{1'b0,1'b0,1'b1,5'd5,5'd1,5'd5,1'b1,1'b1,1'b0,1'b0, C_LU};
        vecs[5]  = '{1'b0,1'b0,1'b1,5'd7,5'd7,5'd2,1'b1,1'b0,1'b0,1'b0, C_LU};
        vecs[6]  = '{1'b0,1'b0,1'b1,5'd0,5'd0,5'd0,1'b1,1'b1,1'b0,1'b0, C_NONE};
        vecs[7]  = '{1'b0,1'b0,1'b1,5'd9,5'd9,5'd9,1'b0,1'b0,1'b0,1'b0, C_NONE};
        vecs[8]  = '{1'b0,1'b0,1'b0,5'd9,5'd9,5'd9,1'b1,1'b1,1'b0,1'b0, C_NONE};
        vecs[9]  = '{1'b1,1'b1,1'b1,5'd4,5'd4,5'd0,1'b1,1'b0,1'b0,1'b0, C_HOLD};
        vecs[10] = '{1'b0,1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,1'b1, C_NONE};
        vecs[11] = '{1'b0,1'b0,1'b1,5'd6,5'd1,5'd6,1'b1,1'b0,1'b0,1'b0, C_NONE};
        @(negedge CLK);
        RESET_N = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            drive(vecs[i].busy, vecs[i].bj, vecs[i].mre, vecs[i].rd, vecs[i].a1, vecs[i].a2,
                  vecs[i].u1, vecs[i].u2, vecs[i].req, vecs[i].done);
            #1;
            check($sformatf("vec%0d", i), ctrl, vecs[i].exp_ctrl);
        end

        // Load-use stall, then bubble clears it; rd=0 never stalls
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);
        #1; check("lu_stall", ctrl, C_LU);
        @(negedge CLK); idle();
        #1; check("lu_after", ctrl, C_NONE);
        check("lu_stallcnt", STALL_CNT, 1);
        drive(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1; check("lu_rd0", ctrl, C_NONE);
        // Redirect beats load-use
        @(negedge CLK);
        drive(1'b0, 1'b1, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);
        #1; check("bj_lu", ctrl, C_REDIR);
        @(negedge CLK); idle();
        #1; check("bj_flushcnt", FLUSH_CNT, 1);
        check("bj_stallcnt", STALL_CNT, 1);

        // MUL/DIV with MD_DONE 5 cycles after launch: 6 held cycles
        do_reset();
        MD_REQ_EX = 1'b1;
        #1; check("md_launch", ctrl, C_LAUNCH);
        for (int i = 1; i <= 5; i++) begin
            @(negedge CLK); #1;
            check($sformatf("md_busy%0d", i), {STATE, 2'b00, ctrl}, {2'd1, 2'b00, C_HOLD});
        end
        @(negedge CLK); MD_DONE = 1'b1;
        #1; check("md_done", {STATE, 2'b00, ctrl}, {2'd1, 2'b00, C_NONE});
        @(negedge CLK); MD_REQ_EX = 1'b0;
        #1; check("md_back", {STATE, 3'b000, MD_ERR}, 0);
        check("md_stallcnt", STALL_CNT, 6);

        // MD_DONE during busywait parks in MD_HELD
        do_reset();
        MD_REQ_EX = 1'b1;
        @(negedge CLK);
        @(negedge CLK); MD_DONE = 1'b1; MEM_BUSYWAIT = 1'b1;
        #1; check("held_entry", {STATE, 2'b00, ctrl}, {2'd1, 2'b00, C_HOLD});
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK); #1;
            check($sformatf("held%0d", i), {STATE, 2'b00, ctrl}, {2'd2, 2'b00, C_HOLD});
        end
        @(negedge CLK); MEM_BUSYWAIT = 1'b0;
        #1; check("held_release", {STATE, 2'b00, ctrl}, {2'd2, 2'b00, C_NONE});
        @(negedge CLK); MD_REQ_EX = 1'b0;
        #1; check("held_run", STATE, 2'd0);

        // Timeout after MD_TIMEOUT cycles in MD_BUSY, sticky MD_ERR
        do_reset();
        MD_REQ_EX = 1'b1;
        for (int i = 1; i < MD_TIMEOUT; i++) begin
            @(negedge CLK); #1;
            check($sformatf("to_busy%0d", i), {STATE, 1'b0, MD_ERR, ctrl}, {2'd1, 2'b00, C_HOLD});
        end
        @(negedge CLK); #1;
        check("to_last", {STATE, 1'b0, MD_ERR, ctrl}, {2'd1, 2'b00, C_NONE});
        @(negedge CLK); MD_REQ_EX = 1'b0;
        #1; check("to_err", {STATE, 1'b0, MD_ERR}, {2'd0, 2'b01});
        repeat (4) @(negedge CLK);
        #1; check("to_sticky", MD_ERR, 1'b1);

        // Asynchronous reset in the middle of MD_BUSY
        MD_REQ_EX = 1'b1;
        repeat (3) @(negedge CLK);
        #1; check("ar_pre", STATE, 2'd1);
        RESET_N = 1'b0;
        #1; check("ar_ctrl", ctrl, C_NONE);
        check("ar_regs", {STATE, MD_ERR, STALL_CNT, FLUSH_CNT}, 0);
        @(negedge CLK); RESET_N = 1'b1;
        #1; check("ar_relaunch", ctrl, C_LAUNCH);

        // Stall counter saturation
        do_reset();
        MEM_BUSYWAIT = 1'b1;
        repeat (20) @(negedge CLK);
        #1; check("sat_stall", STALL_CNT, CNT_SAT);
        repeat (3) @(negedge CLK);
        #1; check("sat_hold", {STALL_CNT, FLUSH_CNT}, {4'd15, 4'd0});

        // Randomized run against the behavioural model
        do_reset();
        md_op = 0; md_mem_wait = 0; m_err = 0; md_cycles = 0; m_stalls = 0; m_flushes = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] exp_c;
            @(negedge CLK); #1;
            check("rnd_regs", {STATE, 1'b0, MD_ERR, STALL_CNT, FLUSH_CNT},
                  {m_state(), 1'b0, m_err, 4'(m_stalls), 4'(m_flushes)});
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 3);
            #1;
            exp_c = m_ctrl();
            check("rnd_ctrl", ctrl, exp_c);
            m_clock(exp_c);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage RV32IM pipeline. It decides every cycle whether PC, IF/ID, ID/EX, EX/MEM and MEM/WB advance, hold or take a bubble. Hazard sources are:
- data-memory busywait;
- taken branch/jump resolved in EX;
- load-use dependency between ID and EX;
- multi-cycle MUL/DIV operation in EX.

It also keeps saturating stall and flush counters for performance debug.

## Interface
- MD_TIMEOUT, 64: max cycles in MD_BUSY before abort; legal range 2..2^TO_W-1.
- TO_W, 7: timeout counter width.
- CNT_W, 16: width of the performance counters.
- CLK  in  1  clock; all state changes on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- MEM_BUSYWAIT  in  1  data memory not ready.
- BJ_TAKEN_EX  in  1  branch/jump in EX is taken (redirect).
- MEM_READ_EN_IDEX  in  1  load in EX.
- REG_WRITE_ADDR_IDEX  in  5  rd of instruction in EX.
- ADDR_1_ID, ADDR_2_ID  in  5 each  rs1/rs2 of instruction in ID.
- USES_RS1_ID, USES_RS2_ID  in  1 each  ID instruction actually reads rs1/rs2.
- MD_REQ_EX  in  1  EX holds a multi-cycle MUL/DIV op.
- MD_DONE  in  1  MUL/DIV unit result valid (level, held until next MD_START).
- PC_HOLD  out  1  PC must not update.
- IFID_HOLD  out  1  IF/ID keeps contents.
- IFID_FLUSH  out  1  IF/ID loads a NOP.
- IDEX_RESET  out  1  ID/EX loads a bubble (drives ID/EX IDEX_RESET).
- PIPE_HOLD  out  1  ID/EX, EX/MEM, MEM/WB hold (drives their busywait/hold input).
- MD_START  out  1  one-cycle launch pulse to MUL/DIV unit.
- MD_ERR  out  1  sticky: MUL/DIV timeout occurred.
- STATE  out  2  debug: 0=RUN, 1=MD_BUSY, 2=MD_HELD.
- STALL_CNT  out  CNT_W  cycles with PC_HOLD=1, saturating.
- FLUSH_CNT  out  CNT_W  cycles with IFID_FLUSH=1, saturating.

## Operation
- Control outputs are combinational from state and inputs (Mealy). All of them are forced to 0 while RESET_N=0.
- Priority within a cycle, highest first: MEM_BUSYWAIT, MD state, BJ_TAKEN_EX, MD_REQ_EX launch, load-use.
- **Busywait:** MEM_BUSYWAIT=1 sets PC_HOLD=IFID_HOLD=PIPE_HOLD=1 and IFID_FLUSH=IDEX_RESET=MD_START=0. Pending redirects/launches are re-evaluated once it drops; held registers keep their inputs stable.
- **RUN, redirect:** BJ_TAKEN_EX=1 sets IFID_FLUSH=1 and IDEX_RESET=1, with PC_HOLD=0 so the target loads. Redirect beats a simultaneous load-use.
- **RUN, MD launch:** MD_REQ_EX=1 without redirect sets MD_START=1 and PC_HOLD=IFID_HOLD=PIPE_HOLD=1. Next state is MD_BUSY and the timeout counter clears to 0.
- **RUN, load-use:** fires when MEM_READ_EN_IDEX=1, REG_WRITE_ADDR_IDEX≠0, and REG_WRITE_ADDR_IDEX matches ADDR_1_ID (with USES_RS1_ID) or ADDR_2_ID (with USES_RS2_ID). It sets PC_HOLD=IFID_HOLD=1 and IDEX_RESET=1 for exactly one cycle; the bubble removes the condition.
- **MD_BUSY:** holds PC/IF/ID/pipe and increments the timeout counter.
  - MD_DONE=1 and MEM_BUSYWAIT=0: release all holds, so EX/MEM captures the result and the pipe advances; next state RUN.
  - MD_DONE=1 and MEM_BUSYWAIT=1: next state MD_HELD.
  - Counter reaches MD_TIMEOUT-1 without MD_DONE: set MD_ERR, release holds; next state RUN.
- **MD_HELD:** holds until MEM_BUSYWAIT=0, then releases for one cycle and returns to RUN. MD_START is never asserted here.
- MD_ERR clears only on reset.
- STALL_CNT and FLUSH_CNT increment at the clock edge following a qualifying cycle and saturate at 2^CNT_W-1.

## Timing
- Reset values: state RUN, timeout counter 0, MD_ERR=0, STALL_CNT=0, FLUSH_CNT=0. All control outputs are 0 during reset.
- Reset mid-MD_BUSY returns to RUN immediately. No MD_START is issued until MD_REQ_EX is re-evaluated after reset release.
- Control outputs have zero latency: they are valid in the same cycle as the inputs, before the next CLK edge.
- MD handshake:
  - MD_START is high only in the RUN cycle that transitions to MD_BUSY.
  - MD_DONE is ignored in RUN.
  - With MD_DONE arriving k cycles after the launch edge, the minimum MD stall is k+1 cycles.
- Redirect flush costs 2 bubbles: the IF/ID slot and the ID/EX slot.

## Test plan
- Load x5 in EX (MEM_READ_EN_IDEX=1, rd=5), ID reads rs2=5 with USES_RS2_ID=1 -> one cycle with PC_HOLD=IFID_HOLD=IDEX_RESET=1, then all 0; STALL_CNT=1. Same case with rd=0 -> no stall.
- BJ_TAKEN_EX=1 together with a load-use match -> IFID_FLUSH=IDEX_RESET=1, PC_HOLD=0; FLUSH_CNT increments by 1.
- MD_REQ_EX=1, MD_DONE asserted 5 cycles after launch -> MD_START high 1 cycle; holds high for 6 cycles total; STATE goes 0,1,…,0; MD_ERR=0.
- MD_DONE arrives while MEM_BUSYWAIT=1 for 3 cycles -> STATE=2 during busywait, holds persist; one release cycle after busywait drops, then RUN.
- MD_TIMEOUT=8 with MD_DONE never asserted -> MD_ERR=1 after 8 MD_BUSY cycles, return to RUN, MD_ERR stays 1 until RESET_N=0.
- Assert RESET_N=0 mid-MD_BUSY -> STATE=0, counters=0, outputs=0 immediately (asynchronous); force STALL_CNT saturation with CNT_W=4 -> holds at 15.
